// File: rtl/pipeline_hazard_controller.sv
// Hazard sequencer for the classic 5-stage pipeline: per-stage enables, bubble/flush strobes,
// post-reset hold, memory-wait freeze with timeout, and saturating stall/flush event counters.
module pipeline_hazard_controller #(
   parameter int unsigned RESET_HOLD  = 4,
   parameter int unsigned MEM_TIMEOUT = 64,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             id_valid,
   input  logic             ex_memtoreg,
   input  logic [4:0]       ex_rt,
   input  logic             br_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             exmem_en,
   output logic             error,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      ST_INIT,
      ST_RUN,
      ST_MEM_WAIT,
      ST_ERROR
   } state_t;

   localparam logic [3:0]       HOLD_LAST = 4'(RESET_HOLD - 1);
   localparam logic [7:0]       WAIT_LAST = 8'(MEM_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   state_t           state_q, state_d;
   logic [3:0]       hold_cnt_q, hold_cnt_d;
   logic [7:0]       wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             stall_inc;
   logic             flush_inc;
   logic             load_use;

   // Register 0 is hardwired zero, so a load targeting it can never create a dependency.
   assign load_use = id_valid & ex_memtoreg & (ex_rt != 5'd0) &
                     ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      exmem_en    = 1'b0;

      case (state_q)
         ST_INIT: begin
            ifid_en     = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_en    = 1'b1;
            hold_cnt_d  = hold_cnt_q + 4'd1;
            if (hold_cnt_q == HOLD_LAST) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (mem_req & ~mem_ready) begin
               state_d    = ST_MEM_WAIT;
               wait_cnt_d = 8'd1;
               stall_inc  = 1'b1;
            end else if (load_use) begin
               // Branch operands are not valid yet, so the stall also masks br_taken.
               idex_bubble = 1'b1;
               exmem_en    = 1'b1;
               stall_inc   = 1'b1;
            end else if (br_taken) begin
               pc_en      = 1'b1;
               ifid_en    = 1'b1;
               ifid_flush = 1'b1;
               exmem_en   = 1'b1;
               flush_inc  = 1'b1;
            end else begin
               pc_en    = 1'b1;
               ifid_en  = 1'b1;
               exmem_en = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            stall_inc = 1'b1;
            if (mem_ready) begin
               state_d = ST_RUN;
            end else if (wait_cnt_q == WAIT_LAST) begin
               state_d = ST_ERROR;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         ST_ERROR: begin
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase

      // While reset is held the pipeline sees the hold pattern even before the first edge.
      if (reset) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b1;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         exmem_en    = 1'b1;
      end
   end

   assign stall_cnt_d = (stall_inc && (stall_cnt_q != CNT_MAX)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
   assign flush_cnt_d = (flush_inc && (flush_cnt_q != CNT_MAX)) ? flush_cnt_q + 1'b1 : flush_cnt_q;

   always_ff @(posedge clk) begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         state_q     <= ST_INIT;
         hold_cnt_q  <= '0;
         wait_cnt_q  <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign error     = (state_q == ST_ERROR);
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Randomized and directed bench for pipeline_hazard_controller against a cycle-level
// behavioural model of the hazard rules.
module tb_pipeline_hazard_controller;

   localparam int RESET_HOLD  = 4;
   localparam int MEM_TIMEOUT = 64;
   localparam int CNT_W       = 8;
   localparam int CNT_MAX     = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [4:0]       id_rs = '0, id_rt = '0, ex_rt = '0;
   logic             id_uses_rt = 1'b0, id_valid = 1'b0, ex_memtoreg = 1'b0;
   logic             br_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
   logic             pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, error;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Model state: cycles of post-reset hold left, memory wait progress, sticky error, counters.
   int m_hold_left = RESET_HOLD;
   bit m_waiting   = 1'b0;
   int m_wait      = 0;
   bit m_err       = 1'b0;
   int m_stall     = 0;
   int m_flush     = 0;

   logic [21:0] exp_v;
   logic [21:0] obs;

   pipeline_hazard_controller #(
      .RESET_HOLD (RESET_HOLD),
      .MEM_TIMEOUT(MEM_TIMEOUT),
      .CNT_W      (CNT_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_uses_rt (id_uses_rt),
      .id_valid   (id_valid),
      .ex_memtoreg(ex_memtoreg),
      .ex_rt      (ex_rt),
      .br_taken   (br_taken),
      .mem_req    (mem_req),
      .mem_ready  (mem_ready),
      .pc_en      (pc_en),
      .ifid_en    (ifid_en),
      .ifid_flush (ifid_flush),
      .idex_bubble(idex_bubble),
      .exmem_en   (exmem_en),
      .error      (error),
      .stall_cnt  (stall_cnt),
      .flush_cnt  (flush_cnt)
   );

   always #5 clk = ~clk;

   assign obs = {pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, error, stall_cnt, flush_cnt};

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   function automatic bit spec_load_use();
      return id_valid && ex_memtoreg && (ex_rt != 0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
   endfunction

   // Expected outputs as {pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en}.
   task automatic model_expect();
      logic [4:0] s;
      if (reset || m_hold_left > 0)                              s = 5'b01111;
      else if (m_err || m_waiting || (mem_req && !mem_ready))    s = 5'b00000;
      else if (spec_load_use())                                  s = 5'b00011;
      else if (br_taken)                                         s = 5'b11101;
      else                                                       s = 5'b11001;
      exp_v = {s, m_err, 8'(m_stall), 8'(m_flush)};
   endtask

   task automatic model_advance();
      if (reset) begin
         m_hold_left = RESET_HOLD;
         m_waiting   = 1'b0;
         m_wait      = 0;
         m_err       = 1'b0;
         m_stall     = 0;
         m_flush     = 0;
      end else if (m_hold_left > 0) begin
         m_hold_left--;
      end else if (m_err) begin
         // frozen until reset
      end else if (m_waiting) begin
         m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : m_stall;
         m_wait++;
         if (mem_ready) m_waiting = 1'b0;
         else if (m_wait >= MEM_TIMEOUT) begin
            m_err     = 1'b1;
            m_waiting = 1'b0;
         end
      end else if (mem_req && !mem_ready) begin
         m_stall   = (m_stall < CNT_MAX) ? m_stall + 1 : m_stall;
         m_waiting = 1'b1;
         m_wait    = 1;
      end else if (spec_load_use()) begin
         m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : m_stall;
      end else if (br_taken) begin
         m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : m_flush;
      end
   endtask

   task automatic settle();
      @(negedge clk);
      model_expect();
   endtask

   task automatic advance();
      model_advance();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                         input logic valid, input logic ld, input logic [4:0] xrt,
                         input logic br, input logic req, input logic rdy);
      id_rs = rs; id_rt = rt; id_uses_rt = uses_rt; id_valid = valid;
      ex_memtoreg = ld; ex_rt = xrt; br_taken = br; mem_req = req; mem_ready = rdy;
   endtask

   task automatic set_idle();
      set_in(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      set_idle();
      advance();
      advance();
      reset = 1'b0;
      repeat (RESET_HOLD) advance();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      set_in(5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0);
      advance();
      for (int i = 0; i < 3; i++) begin
         settle();
         checks++;
         if (obs !== exp_v || {pc_en, ifid_flush, idex_bubble} !== 3'b011) begin
            failures++;
            $display("FAIL reset_held cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
         end
         advance();
      end
      reset = 1'b0;
      set_idle();
      for (int i = 0; i < RESET_HOLD; i++) begin
         settle();
         checks++;
         if (obs !== exp_v || pc_en !== 1'b0 || ifid_flush !== 1'b1) begin
            failures++;
            $display("FAIL reset_hold%0d cyc=%0d got=%h exp=%h", i, cyc, obs, exp_v);
         end
         advance();
      end
      settle();
      checks++;
      if (obs !== exp_v || pc_en !== 1'b1 || ifid_flush !== 1'b0) begin
         failures++;
         $display("FAIL reset_run cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
      end
   endtask

   task automatic test_load_use();
      do_reset();
      set_in(5'd5, 5'd9, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
      settle();
      checks++;
      if (obs !== exp_v || {pc_en, ifid_en, idex_bubble, exmem_en} !== 4'b0011) begin
         failures++;
         $display("FAIL load_use_rs got=%h exp=%h", obs, exp_v);
      end
      advance();
      set_in(5'd1, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1);
      settle();
      checks++;
      if (obs !== exp_v || pc_en !== 1'b0 || idex_bubble !== 1'b1) begin
         failures++;
         $display("FAIL load_use_rt got=%h exp=%h", obs, exp_v);
      end
      advance();
      set_idle();
      settle();
      checks++;
      if (obs !== exp_v || stall_cnt !== 8'd2 || pc_en !== 1'b1) begin
         failures++;
         $display("FAIL load_use_after stall_cnt=%0d exp=2 got=%h", stall_cnt, obs);
      end
   endtask

   task automatic test_no_stall();
      do_reset();
      set_in(5'd0, 5'd4, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
      settle();
      checks++;
      if (obs !== exp_v || {pc_en, ifid_en, idex_bubble, exmem_en} !== 4'b1101) begin
         failures++;
         $display("FAIL no_stall_r0 got=%h exp=%h", obs, exp_v);
      end
      advance();
      set_in(5'd5, 5'd5, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
      settle();
      checks++;
      if (obs !== exp_v || {pc_en, ifid_en, idex_bubble, exmem_en} !== 4'b1101) begin
         failures++;
         $display("FAIL no_stall_invalid got=%h exp=%h", obs, exp_v);
      end
      advance();
      set_in(5'd1, 5'd6, 1'b0, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b1);
      settle();
      checks++;
      if (obs !== exp_v || pc_en !== 1'b1 || stall_cnt !== 8'd0) begin
         failures++;
         $display("FAIL no_stall_rt_unused got=%h exp=%h", obs, exp_v);
      end
      advance();
   endtask

   task automatic test_branch();
      do_reset();
      set_in(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
      settle();
      checks++;
      if (obs !== exp_v || {pc_en, ifid_en, ifid_flush, exmem_en} !== 4'b1111) begin
         failures++;
         $display("FAIL branch_flush got=%h exp=%h", obs, exp_v);
      end
      advance();
      set_in(5'd3, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1);
      settle();
      checks++;
      if (obs !== exp_v || flush_cnt !== 8'd1 || pc_en !== 1'b0 || ifid_flush !== 1'b0) begin
         failures++;
         $display("FAIL branch_vs_stall got=%h exp=%h", obs, exp_v);
      end
      advance();
      set_idle();
      settle();
      checks++;
      if (obs !== exp_v || flush_cnt !== 8'd1 || stall_cnt !== 8'd1) begin
         failures++;
         $display("FAIL branch_counts got=%h exp=%h", obs, exp_v);
      end
   endtask

   task automatic test_mem_wait();
      do_reset();
      set_in(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         if (i == 3) mem_ready = 1'b1;
         settle();
         checks++;
         if (obs !== exp_v || {pc_en, ifid_en, exmem_en} !== 3'b000) begin
            failures++;
            $display("FAIL mem_wait%0d got=%h exp=%h", i, obs, exp_v);
         end
         advance();
      end
      set_idle();
      settle();
      checks++;
      if (obs !== exp_v || exmem_en !== 1'b1 || stall_cnt !== 8'd4) begin
         failures++;
         $display("FAIL mem_wait_resume stall_cnt=%0d exp=4 got=%h", stall_cnt, obs);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      set_in(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < MEM_TIMEOUT; i++) begin
         settle();
         checks++;
         if (obs !== exp_v || exmem_en !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL timeout_wait%0d got=%h exp=%h", i, obs, exp_v);
         end
         advance();
      end
      settle();
      checks++;
      if (obs !== exp_v || error !== 1'b1 || stall_cnt !== 8'(MEM_TIMEOUT)) begin
         failures++;
         $display("FAIL timeout_error error=%b stall_cnt=%0d got=%h exp=%h", error, stall_cnt, obs, exp_v);
      end
      mem_ready = 1'b1;
      repeat (5) advance();
      settle();
      checks++;
      if (obs !== exp_v || error !== 1'b1 || exmem_en !== 1'b0) begin
         failures++;
         $display("FAIL timeout_sticky got=%h exp=%h", obs, exp_v);
      end
      reset = 1'b1;
      advance();
      settle();
      checks++;
      if (obs !== exp_v || error !== 1'b0 || stall_cnt !== 8'd0 || ifid_flush !== 1'b1) begin
         failures++;
         $display("FAIL timeout_reset got=%h exp=%h", obs, exp_v);
      end
      reset = 1'b0;
      advance();
   endtask

   task automatic test_saturation();
      do_reset();
      set_in(5'd4, 5'd4, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b1);
      repeat (CNT_MAX + 20) advance();
      set_in(5'd4, 5'd4, 1'b1, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1);
      repeat (CNT_MAX + 20) advance();
      set_idle();
      settle();
      checks++;
      if (obs !== exp_v || stall_cnt !== 8'hFF || flush_cnt !== 8'hFF) begin
         failures++;
         $display("FAIL saturation stall=%0d flush=%0d exp=255/255", stall_cnt, flush_cnt);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 199) == 0);
         set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                1'($urandom_range(0, 3) != 0), 1'($urandom), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 1)));
         settle();
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
         end
         advance();
      end
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_no_stall();
      test_branch();
      test_mem_wait();
      test_timeout();
      test_saturation();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
